ifid_queue: RTL and testbench

Parametrised IF/ID boundary queue that replaces the single-entry IF/ID register between fetch and decode. It buffers up to DEPTH fetched {next-PC, instruction} packets behind a valid/ready handshake on both sides, so fetch can run ahead of a stalled decode. It also supports a one-cycle flush for branch redirects and presents a NOP to decode whenever it holds nothing.

---
 rtl/ifid_queue.sv | 130 +++++++++++++
 tb/tb_ifid_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_queue.sv
`default_nettype none
// ============================================================================
//  Module      : ifid_queue
//  Description : IF/ID boundary queue. Buffers up to DEPTH {next-PC, instr}
//                packets between fetch and decode with valid/ready on both
//                sides, first-word fall-through head, single-cycle flush and
//                a NOP presented to decode whenever the queue is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifid_queue #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter int                 DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // fetch side
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_W-1:0]              in_next_pc,
  input  logic [INSTR_W-1:0]           in_instr,
  // decode side
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_next_pc,
  output logic [INSTR_W-1:0]           out_instr,
  // control / status
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam int c_ENT_W = PC_W + INSTR_W;

  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

  // Storage and bookkeeping state
  logic [c_ENT_W-1:0] mem_q [DEPTH];
  logic [c_ENT_W-1:0] mem_d [DEPTH];
  logic [c_PTR_W-1:0] wptr_q, wptr_d;
  logic [c_PTR_W-1:0] rptr_q, rptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;

  // Handshake qualifiers
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [c_ENT_W-1:0] w_head;

  // Status flags depend only on registered count, so neither ready nor valid
  // has a combinational path from the opposite side of the queue.
  always_comb begin
    w_full  = (count_q == c_CNT_FULL);
    w_empty = (count_q == '0);
    w_push  = in_valid  & ~w_full  & ~flush;
    w_pop   = out_ready & ~w_empty & ~flush;
  end

  // Pointer and occupancy next-state; flush overrides any push or pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so plain overflow wraps the pointers.
      if (w_push) begin
        wptr_d = wptr_q + c_PTR_ONE;
      end
      if (w_pop) begin
        rptr_d = rptr_q + c_PTR_ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   count_d = count_q + c_CNT_ONE;
        2'b01:   count_d = count_q - c_CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Array next-state: only the entry at the write pointer changes on a push.
  always_comb begin
    mem_d = mem_q;
    if (w_push) begin
      mem_d[wptr_q] = {in_next_pc, in_instr};
    end
  end

  // Control registers, cleared asynchronously so outputs drop to idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Packet storage carries no reset; empty-state muxing hides stale contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // First-word fall-through head, forced to a NOP bubble while empty.
  always_comb begin
    w_head      = mem_q[rptr_q];
    in_ready    = ~w_full;
    out_valid   = ~w_empty;
    count       = count_q;
    out_next_pc = '0;
    out_instr   = NOP_INSTR;
    if (!w_empty) begin
      out_next_pc = w_head[c_ENT_W-1:INSTR_W];
      out_instr   = w_head[INSTR_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifid_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifid_queue
//  Description : Self-checking bench for ifid_queue. Two instances run side by
//                side (16/16/DEPTH=4 and 32/32/DEPTH=2) against a list-based
//                reference model, with directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifid_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv   [2];
  logic        ordy [2];
  logic        fl   [2];
  logic [31:0] ipc  [2];
  logic [31:0] iins [2];

  logic        ir0, ov0;
  logic [15:0] opc0, oins0;
  logic [2:0]  cnt0;
  logic        ir1, ov1;
  logic [31:0] opc1, oins1;
  logic [1:0]  cnt1;

  ifid_queue #(.PC_W(16), .INSTR_W(16), .DEPTH(4), .NOP_INSTR(16'h0800)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir0), .in_next_pc(ipc[0][15:0]), .in_instr(iins[0][15:0]),
    .out_valid(ov0), .out_ready(ordy[0]), .out_next_pc(opc0), .out_instr(oins0),
    .flush(fl[0]), .count(cnt0)
  );

  ifid_queue #(.PC_W(32), .INSTR_W(32), .DEPTH(2), .NOP_INSTR(32'h00000013)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir1), .in_next_pc(ipc[1]), .in_instr(iins[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .out_next_pc(opc1), .out_instr(oins1),
    .flush(fl[1]), .count(cnt1)
  );

  function automatic int depth_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic [31:0] nop_of(input int i);
    return (i == 0) ? 32'h0000_0800 : 32'h0000_0013;
  endfunction

  function automatic logic [31:0] mask_of(input int i);
    return (i == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // ---------------------------------------------------------------- model
  // Each queue is an ordered list: pop removes element 0, push appends.
  logic [63:0] mdata [2][4];
  int          msize [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      logic [63:0] t [4];
      int          ts;
      logic        do_push, do_pop;
      for (int k = 0; k < 4; k++) t[k] = mdata[i][k];
      ts = msize[i];
      if (!rst_n || fl[i]) begin
        ts = 0;
      end else begin
        do_push = iv[i] && (ts < depth_of(i));
        do_pop  = ordy[i] && (ts > 0);
        if (do_pop) begin
          for (int k = 0; k < 3; k++) t[k] = t[k+1];
          ts = ts - 1;
        end
        if (do_push) begin
          t[ts] = {ipc[i] & mask_of(i), iins[i] & mask_of(i)};
          ts = ts + 1;
        end
      end
      for (int k = 0; k < 4; k++) mdata[i][k] <= t[k];
      msize[i] <= ts;
    end
  end

  // ---------------------------------------------------------------- checks
  int n_chk  = 0;
  int n_fail = 0;

  // Hand-computed expectations posted by the stimulus, consumed below.
  int          pin_seq = 0;
  int          pin_done = 0;
  int          pin_inst;
  logic        pin_v, pin_r;
  logic [31:0] pin_c, pin_ins;
  string       pin_name;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst%0d] at %0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  task automatic get_act(input int i, output logic v, output logic r,
                         output logic [31:0] c, output logic [31:0] pc, output logic [31:0] ins);
    if (i == 0) begin
      v = ov0; r = ir0; c = {29'b0, cnt0}; pc = {16'b0, opc0}; ins = {16'b0, oins0};
    end else begin
      v = ov1; r = ir1; c = {30'b0, cnt1}; pc = opc1; ins = oins1;
    end
  endtask

  // Compare every DUT output against the model each cycle, mid-period.
  always @(negedge clk) begin
    logic        v, r;
    logic [31:0] c, pc, ins;
    for (int i = 0; i < 2; i++) begin
      int sz;
      sz = msize[i];
      get_act(i, v, r, c, pc, ins);
      chk("out_valid", i, {31'b0, v}, {31'b0, (sz != 0)});
      chk("in_ready",  i, {31'b0, r}, {31'b0, (sz != depth_of(i))});
      chk("count",     i, c, 32'(sz));
      chk("out_instr", i, ins, (sz != 0) ? mdata[i][0][31:0]  : nop_of(i));
      chk("out_pc",    i, pc,  (sz != 0) ? mdata[i][0][63:32] : 32'h0);
    end
    if (pin_seq != pin_done) begin
      pin_done = pin_seq;
      get_act(pin_inst, v, r, c, pc, ins);
      chk({pin_name, "_valid"}, pin_inst, {31'b0, v}, {31'b0, pin_v});
      chk({pin_name, "_ready"}, pin_inst, {31'b0, r}, {31'b0, pin_r});
      chk({pin_name, "_count"}, pin_inst, c, pin_c);
      chk({pin_name, "_instr"}, pin_inst, ins, pin_ins);
      chk({pin_name, "_model"}, pin_inst, 32'(msize[pin_inst]), pin_c);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pin(input int i, input logic v, input logic r, input int c,
                     input logic [31:0] ins, input string nm);
    pin_inst = i; pin_v = v; pin_r = r; pin_c = 32'(c); pin_ins = ins; pin_name = nm;
    pin_seq++;
  endtask

  task automatic fill_drain(input int i);
    iv[i] = 1'b1; ordy[i] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ipc[i] = 32'(k); iins[i] = 32'hA000 + 32'(k);
      tick();
    end
    iv[i] = 1'b0;
    pin(i, 1'b1, 1'b0, depth_of(i), 32'hA000, "fill_full");
    ordy[i] = 1'b1;
    repeat (depth_of(i) + 1) tick();
    ordy[i] = 1'b0;
    pin(i, 1'b0, 1'b1, 0, nop_of(i), "drain_empty");
    tick();
  endtask

  task automatic flush_case(input int i);
    int n;
    n = (depth_of(i) < 3) ? depth_of(i) : 3;
    iv[i] = 1'b1; ordy[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      ipc[i] = 32'h10 + 32'(k); iins[i] = 32'hE000 + 32'(k);
      tick();
    end
    fl[i] = 1'b1; ordy[i] = 1'b1; iins[i] = 32'hDEAD; ipc[i] = 32'hBEEF;
    tick();
    fl[i] = 1'b0; ordy[i] = 1'b0;
    iins[i] = 32'hC000; ipc[i] = 32'h44;
    pin(i, 1'b0, 1'b1, 0, nop_of(i), "flush_empty");
    tick();
    iv[i] = 1'b0;
    pin(i, 1'b1, 1'b1, 1, 32'hC000, "after_flush");
    ordy[i] = 1'b1;
    tick();
    ordy[i] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; fl[i] = 1'b0; ipc[i] = '0; iins[i] = '0;
    end
    tick();
    pin(0, 1'b0, 1'b1, 0, 32'h0800, "reset");
    tick();
    pin(1, 1'b0, 1'b1, 0, 32'h0000_0013, "reset");
    tick();
    rst_n = 1'b1;

    // single packet through the default instance
    iv[0] = 1'b1; ipc[0] = 32'h0002; iins[0] = 32'h1234;
    tick();
    iv[0] = 1'b0;
    pin(0, 1'b1, 1'b1, 1, 32'h1234, "single_push");
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    pin(0, 1'b0, 1'b1, 0, 32'h0800, "single_pop");
    tick();

    fill_drain(0);
    fill_drain(1);

    // streaming at count 2 across pointer wrap
    iv[0] = 1'b1; ordy[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iins[0] = 32'hB000 + 32'(k); ipc[0] = 32'(k); tick();
    end
    ordy[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      iins[0] = 32'hB002 + 32'(j); ipc[0] = 32'(j + 2);
      tick();
      if (j == 5) pin(0, 1'b1, 1'b1, 2, 32'hB006, "stream");
    end
    iv[0] = 1'b0;
    repeat (3) tick();
    ordy[0] = 1'b0;

    flush_case(0);
    flush_case(1);

    // asynchronous reset with entries held
    iv[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iins[0] = 32'hD000 + 32'(k); tick();
    end
    iv[0] = 1'b0;
    rst_n = 1'b0;
    pin(0, 1'b0, 1'b1, 0, 32'h0800, "async_reset");
    tick();
    rst_n = 1'b1;
    tick();

    // random traffic on both instances
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        ordy[i] = ($urandom_range(0, 2) != 0) ^ (n[6] == 1'b1);
        fl[i]   = ($urandom_range(0, 29) == 0);
        ipc[i]  = $urandom;
        iins[i] = $urandom;
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; fl[i] = 1'b0;
    end
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
